systolic_core: RTL and testbench

//   Output-stationary MAX_DIM x MAX_DIM grid of MAC processing elements (PEs) behind the operand skew/pad stage.
//   - Consumes the skewed A-row and B-column lane vectors plus the start/done handshake of that stage.
//   - Accumulates C = A*B in place, drains the pipeline, then presents a registered flat C matrix with a valid flag.
//   - Its C output feeds the padding stage's C input, which masks elements outside N x M.

---
 rtl/systolic_core.sv | 191 +++++++++++++++++++
 tb/tb_systolic_core.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_core.sv
// systolic_core: output-stationary MAX_DIM x MAX_DIM MAC grid behind the operand skew stage.
// A lanes flow right and B lanes flow down. Each PE accumulates its C element in place.
// After done rises, the grid drains and then captures C into a registered flat bus.
// Optional feature macro SYSTOLIC_SAT_EN: saturating accumulators with sticky per-element overflow.
module systolic_core #(
  parameter int unsigned DW        = 8,
  parameter int unsigned BW        = 32,
  parameter int unsigned DRAIN_CYC = 2 * (BW / DW)
) (
  input  logic                                   clk_i,
  input  logic                                   reset_ni,
  input  logic                                   start_bit_i,
  input  logic                                   done_sig_i,
  input  logic [(BW/DW)*DW-1:0]                  vec_a_i,
  input  logic [(BW/DW)*DW-1:0]                  vec_b_i,
  output logic [BW*(BW/DW)*(BW/DW)-1:0]          c_flat_o,
  output logic                                   c_valid_o,
  output logic                                   busy_o,
  output logic [(BW/DW)*(BW/DW)-1:0]             ovf_o
);

  localparam int unsigned MAX_DIM = BW / DW;
  localparam int unsigned CW      = $clog2(DRAIN_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ACCUM   = 3'd1,
    S_DRAIN   = 3'd2,
    S_CAPTURE = 3'd3,
    S_HOLD    = 3'd4
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_done_q;
  logic            r_valid;
  logic            r_busy;
  logic            w_done_rise;
  logic            w_clr;
  logic            w_en;
  logic            w_cap;

  // Operand forwarding paths: only PEs that feed a neighbour keep an operand register.
  logic [DW-1:0]   w_a_q [MAX_DIM][MAX_DIM-1];
  logic [DW-1:0]   w_b_q [MAX_DIM-1][MAX_DIM];

  assign w_done_rise = done_sig_i & ~r_done_q;
  assign w_clr       = (r_state == S_IDLE) & start_bit_i;
  assign w_en        = (r_state == S_ACCUM) | (r_state == S_DRAIN);
  assign w_cap       = (r_state == S_CAPTURE);
  assign c_valid_o   = r_valid;
  assign busy_o      = r_busy;

  // Run control: start clears the grid, done rise starts the drain, capture then hold.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_done_q <= 1'b0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_done_q <= done_sig_i;
      case (r_state)
        S_IDLE: begin
          if (start_bit_i) begin
            r_state <= S_ACCUM;
            r_valid <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        S_ACCUM: begin
          if (w_done_rise) begin
            r_state <= S_DRAIN;
            r_cnt   <= '0;
          end
        end
        S_DRAIN: begin
          if (r_cnt == CW'(DRAIN_CYC - 1)) begin
            r_state <= S_CAPTURE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_CAPTURE: begin
          r_valid <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_HOLD;
        end
        S_HOLD: begin
          if (!start_bit_i) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifndef SYSTOLIC_SAT_EN
  assign ovf_o = '0;
`endif

  for (genvar i = 0; i < MAX_DIM; i++) begin : g_row
    for (genvar j = 0; j < MAX_DIM; j++) begin : g_col
      logic [DW-1:0]   w_a_in;
      logic [DW-1:0]   w_b_in;
      logic [2*DW-1:0] w_prod;
      logic [BW-1:0]   r_acc;
      logic [BW-1:0]   r_c;

      if (j == 0) begin : g_a_edge
        assign w_a_in = vec_a_i[i*DW +: DW];
      end else begin : g_a_int
        assign w_a_in = w_a_q[i][j-1];
      end

      if (i == 0) begin : g_b_edge
        assign w_b_in = vec_b_i[j*DW +: DW];
      end else begin : g_b_int
        assign w_b_in = w_b_q[i-1][j];
      end

      assign w_prod = (2*DW)'(w_a_in) * (2*DW)'(w_b_in);

      if (j < MAX_DIM - 1) begin : g_a_reg
        logic [DW-1:0] r_a;
        // A operand pipeline towards the next column.
        always_ff @(posedge clk_i) begin
          if (!reset_ni || w_clr) r_a <= '0;
          else if (w_en)          r_a <= w_a_in;
        end
        assign w_a_q[i][j] = r_a;
      end

      if (i < MAX_DIM - 1) begin : g_b_reg
        logic [DW-1:0] r_b;
        // B operand pipeline towards the next row.
        always_ff @(posedge clk_i) begin
          if (!reset_ni || w_clr) r_b <= '0;
          else if (w_en)          r_b <= w_b_in;
        end
        assign w_b_q[i][j] = r_b;
      end

`ifdef SYSTOLIC_SAT_EN
      logic [BW:0] w_sum;
      logic        r_ovf;
      logic        r_ovf_c;
      assign w_sum = {1'b0, r_acc} + (BW+1)'(w_prod);
      // Saturating accumulate with sticky overflow flag.
      always_ff @(posedge clk_i) begin
        if (!reset_ni || w_clr) begin
          r_acc <= '0;
          r_ovf <= 1'b0;
        end else if (w_en) begin
          if (w_sum[BW]) begin
            r_acc <= '1;
            r_ovf <= 1'b1;
          end else begin
            r_acc <= w_sum[BW-1:0];
          end
        end
      end
      // Overflow flag published with the captured result.
      always_ff @(posedge clk_i) begin
        if (!reset_ni) r_ovf_c <= 1'b0;
        else if (w_cap) r_ovf_c <= r_ovf;
      end
      assign ovf_o[i*MAX_DIM+j] = r_ovf_c;
`else
      // Wrapping accumulate.
      always_ff @(posedge clk_i) begin
        if (!reset_ni || w_clr) r_acc <= '0;
        else if (w_en)          r_acc <= r_acc + BW'(w_prod);
      end
`endif

      // Result register, loaded only at capture.
      always_ff @(posedge clk_i) begin
        if (!reset_ni) r_c <= '0;
        else if (w_cap) r_c <= r_acc;
      end
      assign c_flat_o[(i*MAX_DIM+j)*BW +: BW] = r_c;
    end
  end

endmodule

// File: tb/tb_systolic_core.sv
// Bench for systolic_core: directed matrix cases plus random matrices against a plain matrix-product model.
// A second instance at BW=16 covers accumulator overflow.
module tb_systolic_core;

  localparam int unsigned DW   = 8;
  localparam int unsigned BW   = 32;
  localparam int unsigned D    = BW / DW;
  localparam int unsigned DRN  = 2 * D;
  localparam int unsigned BW2  = 16;
  localparam int unsigned D2   = BW2 / DW;

  logic clk = 1'b0;
  logic reset_n;
  logic start, done;
  logic [D*DW-1:0]      va, vb;
  logic [BW*D*D-1:0]    c_flat;
  logic                 c_valid, busy;
  logic [D*D-1:0]       ovf;

  logic start2, done2;
  logic [D2*DW-1:0]     va2, vb2;
  logic [BW2*D2*D2-1:0] c_flat2;
  logic                 c_valid2, busy2;
  logic [D2*D2-1:0]     ovf2;

  int n_checks = 0;
  int n_errors = 0;

  int unsigned ma [D][D];
  int unsigned mb [D][D];

  always #5 clk = ~clk;

  systolic_core #(.DW(DW), .BW(BW)) u_dut (
    .clk_i(clk), .reset_ni(reset_n), .start_bit_i(start), .done_sig_i(done),
    .vec_a_i(va), .vec_b_i(vb), .c_flat_o(c_flat), .c_valid_o(c_valid),
    .busy_o(busy), .ovf_o(ovf)
  );

  systolic_core #(.DW(DW), .BW(BW2)) u_dut16 (
    .clk_i(clk), .reset_ni(reset_n), .start_bit_i(start2), .done_sig_i(done2),
    .vec_a_i(va2), .vec_b_i(vb2), .c_flat_o(c_flat2), .c_valid_o(c_valid2),
    .busy_o(busy2), .ovf_o(ovf2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [31:0] elem(input int i, input int j);
    logic [BW*D*D-1:0] f;
    f = c_flat;
    return f[(i*D+j)*BW +: BW];
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Reference: plain matrix product, wrapped or clamped at 2^BW.
  task automatic check_result(input string tag);
    longint sum;
    logic [63:0] expv;
    logic [D*D-1:0] eovf;
    eovf = '0;
    for (int i = 0; i < int'(D); i++) begin
      for (int j = 0; j < int'(D); j++) begin
        sum = 0;
        for (int k = 0; k < int'(D); k++) sum += longint'(ma[i][k]) * longint'(mb[k][j]);
`ifdef SYSTOLIC_SAT_EN
        if (sum > 64'hFFFF_FFFF) begin expv = 64'hFFFF_FFFF; eovf[i*D+j] = 1'b1; end
        else expv = 64'(sum);
`else
        expv = 64'(sum) & 64'hFFFF_FFFF;
`endif
        check($sformatf("%s_c%0d%0d", tag, i, j), 64'(elem(i, j)), expv);
      end
    end
    check({tag, "_ovf"}, 64'(ovf), 64'(eovf));
  endtask

  // Skewed feeder + done pulse; checks clear, latency and result.
  task automatic run_main(input string tag);
    int lat;
    start = 1'b1;
    tick();
    check({tag, "_clr_valid"}, 64'(c_valid), 64'd0);
    check({tag, "_busy_acc"}, 64'(busy), 64'd1);
    for (int t = 0; t < int'(2*D-1); t++) begin
      for (int i = 0; i < int'(D); i++) begin
        va[i*DW +: DW] = (t - i >= 0 && t - i < int'(D)) ? DW'(ma[i][t-i]) : '0;
        vb[i*DW +: DW] = (t - i >= 0 && t - i < int'(D)) ? DW'(mb[t-i][i]) : '0;
      end
      tick();
    end
    va = '0; vb = '0; done = 1'b1;
    tick();
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (n == 1) check({tag, "_busy_drain"}, 64'(busy), 64'd1);
      if (c_valid) begin lat = n; break; end
    end
    check({tag, "_latency"}, 64'(lat), 64'(DRN + 1));
    check({tag, "_busy_hold"}, 64'(busy), 64'd0);
    check_result(tag);
  endtask

  task automatic release_run();
    start = 1'b0; done = 1'b0;
    tick();
  endtask

  task automatic set_ab(input int unsigned a [D][D], input int unsigned b [D][D]);
    ma = a; mb = b;
  endtask

  initial begin
    int unsigned za [D][D];
    int unsigned ta [D][D];
    int unsigned tb [D][D];
    logic [31:0] held;
    int lat2;
    int n, k, m;

    reset_n = 1'b0; start = 1'b0; done = 1'b0; va = '0; vb = '0;
    start2 = 1'b0; done2 = 1'b0; va2 = '0; vb2 = '0;
    tick(); tick();
    check("rst_cflat", 64'(|c_flat), 64'd0);
    check("rst_valid", 64'(c_valid), 64'd0);
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_ovf",   64'(ovf), 64'd0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < int'(D); i++)
      for (int j = 0; j < int'(D); j++) za[i][j] = 0;

    // Identity times B.
    ta = za; tb = za;
    for (int i = 0; i < int'(D); i++) begin
      ta[i][i] = 1;
      for (int j = 0; j < int'(D); j++) tb[i][j] = 32'(i*4 + j + 1);
    end
    set_ab(ta, tb);
    run_main("t1");
    check("t1_c23_literal", 64'(elem(2, 3)), 64'd12);

    // Back-to-back: start held high in HOLD keeps the result.
    held = elem(1, 2);
    done = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("t6_hold_valid", 64'(c_valid), 64'd1);
      check("t6_hold_busy", 64'(busy), 64'd0);
    end
    check("t6_hold_c12", 64'(elem(1, 2)), 64'(held));
    release_run();
    check("t6_valid_in_idle", 64'(c_valid), 64'd1);

    // Non-square 2x3 by 3x2 (Test 3), run straight after.
    ta = za; tb = za;
    ta[0][0] = 1; ta[0][1] = 2; ta[0][2] = 3;
    ta[1][0] = 4; ta[1][1] = 5; ta[1][2] = 6;
    tb[0][0] = 7;  tb[0][1] = 8;
    tb[1][0] = 9;  tb[1][1] = 10;
    tb[2][0] = 11; tb[2][1] = 12;
    set_ab(ta, tb);
    run_main("t3");
    check("t3_c00_lit", 64'(elem(0, 0)), 64'd58);
    check("t3_c11_lit", 64'(elem(1, 1)), 64'd154);
    release_run();

    // All-255 operands.
    for (int i = 0; i < int'(D); i++)
      for (int j = 0; j < int'(D); j++) begin ta[i][j] = 255; tb[i][j] = 255; end
    set_ab(ta, tb);
    run_main("t2");
    check("t2_c33_lit", 64'(elem(3, 3)), 64'h0003_F804);
    release_run();

    // Reset in the middle of ACCUM discards everything.
    start = 1'b1;
    tick();
    va = '1; vb = '1;
    tick(); tick();
    reset_n = 1'b0; start = 1'b0; va = '0; vb = '0;
    tick();
    check("t5_cflat", 64'(|c_flat), 64'd0);
    check("t5_valid", 64'(c_valid), 64'd0);
    check("t5_busy",  64'(busy), 64'd0);
    reset_n = 1'b1;
    tick(); tick();
    check("t5_idle_busy", 64'(busy), 64'd0);
    ta = za; tb = za;
    ta[0][0] = 3; ta[3][3] = 9; tb[0][3] = 5; tb[3][0] = 7;
    set_ab(ta, tb);
    run_main("t5run");
    release_run();

    // Random N x K by K x M matrices, zero outside their shape.
    for (int r = 0; r < 6; r++) begin
      n = int'($urandom_range(1, D)); k = int'($urandom_range(1, D)); m = int'($urandom_range(1, D));
      ta = za; tb = za;
      for (int i = 0; i < n; i++) for (int x = 0; x < k; x++) ta[i][x] = $urandom_range(0, 255);
      for (int x = 0; x < k; x++) for (int j = 0; j < m; j++) tb[x][j] = $urandom_range(0, 255);
      set_ab(ta, tb);
      run_main($sformatf("rnd%0d", r));
      release_run();
    end

    // Narrow accumulator: 2x2 all-255, true sum 130050.
    start2 = 1'b1;
    tick();
    for (int t = 0; t < int'(2*D2-1); t++) begin
      for (int i = 0; i < int'(D2); i++) begin
        va2[i*DW +: DW] = (t - i >= 0 && t - i < int'(D2)) ? 8'hFF : 8'h00;
        vb2[i*DW +: DW] = (t - i >= 0 && t - i < int'(D2)) ? 8'hFF : 8'h00;
      end
      tick();
    end
    va2 = '0; vb2 = '0; done2 = 1'b1;
    tick();
    lat2 = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c_valid2) begin lat2 = c; break; end
    end
    check("t4_latency", 64'(lat2), 64'(2*D2 + 1));
    for (int e = 0; e < int'(D2*D2); e++) begin
`ifdef SYSTOLIC_SAT_EN
      check($sformatf("t4_c%0d", e), 64'(c_flat2[e*BW2 +: BW2]), 64'd65535);
`else
      check($sformatf("t4_c%0d", e), 64'(c_flat2[e*BW2 +: BW2]), 64'd64514);
`endif
    end
`ifdef SYSTOLIC_SAT_EN
    check("t4_ovf", 64'(ovf2), 64'hF);
`else
    check("t4_ovf", 64'(ovf2), 64'h0);
`endif
    start2 = 1'b0; done2 = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
